dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_bytearray.sv | 34 +++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared load/store definitions for the core and the data-memory responder.
// Holds the RV32I load/store funct3 encodings, the responder FSM state codes
// and the request legality check used when a request is latched.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

  // 1 when the request must be answered with an error and no array access:
  // an unknown funct3 for the direction, or a halfword/word not naturally aligned.
  function automatic logic dmem_req_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic bad_f3;
    logic misal;
    if (we) bad_f3 = f3[2] | (f3[1:0] == 2'b11);
    else    bad_f3 = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    misal = ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
    return bad_f3 | misal;
  endfunction

endpackage

// File: rtl/dmem_bytearray.sv
// Word-organised data store with per-byte write enables and a registered read.
// Ports:
//   clk          clock
//   we, be       write strobe and byte-lane enables (lane i = bits 8i+7:8i)
//   re           read strobe; rdata updates at the edge where re is high
//   addr         word index (byte address >> 2)
//   wdata        lane-steered write data
//   rdata        registered read word, held until the next read
// The array is deliberately not reset so stored data survives rst.
module dmem_bytearray #(
  parameter int ADDRW     = 12,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [3:0]       be,
  input  logic [ADDRW-3:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam int          DEPTH  = 2**(ADDRW-2);
  localparam logic [31:0] INIT_W = INIT_ZERO ? 32'h0 : 32'hx;

  logic [3:0][7:0] mem [DEPTH] = '{default: INIT_W};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][i] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding RV32I data-memory responder.
// A request is latched in IDLE, the array is accessed for exactly one cycle
// (ACCESS), then the response is presented in RESP until the initiator takes it.
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr,    request fields: direction, size/sign,
//   req_wdata                        byte address, right-aligned store data
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_err               extended load data (0 for stores/errors), error flag
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDRW     = 12,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err
);

  dmem_state_e      state, state_nxt;
  logic             we_q, err_q;
  logic [2:0]       f3_q;
  logic [ADDRW-1:0] addr_q;
  logic [31:0]      wdata_q;

  logic [3:0]       be;
  logic [31:0]      wlane, rword, rshift, ldata;
  logic             arr_we, arr_re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (req_valid && req_ready) begin
      we_q    <= req_we;
      err_q   <= dmem_req_err(req_we, req_funct3, req_addr[1:0]);
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the
  // destination bytes; aligned halfwords land on lanes 0-1 or 2-3 only.
  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr_q[1:0];
        wlane = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Gated on state so an async reset during ACCESS drops the commit at once.
  assign arr_we = (state == ST_ACCESS) &  we_q & ~err_q;
  assign arr_re = (state == ST_ACCESS) & ~we_q & ~err_q;

  dmem_bytearray #(
    .ADDRW     (ADDRW),
    .INIT_ZERO (INIT_ZERO)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .be    (be),
    .addr  (addr_q[ADDRW-1:2]),
    .wdata (wlane),
    .rdata (rword)
  );

  // The read word only changes on an ACCESS edge, so it stays stable in RESP.
  assign rshift = rword >> {addr_q[1:0], 3'b000};

  always_comb begin
    ldata = '0;
    case (f3_q)
      F3_B:    ldata = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    ldata = {{16{rshift[15]}}, rshift[15:0]};
      F3_W:    ldata = rshift;
      F3_BU:   ldata = {24'h0, rshift[7:0]};
      F3_HU:   ldata = {16'h0, rshift[15:0]};
      default: ldata = '0;
    endcase
  end

  assign rsp_rdata = (state == ST_RESP && !we_q && !err_q) ? ldata : '0;
  assign rsp_err   = (state == ST_RESP) & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: store/load lanes, extension, errors,
// response back-pressure and reset abort of an in-flight store.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int ADDRW = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [2:0]       req_funct3 = '0;
  logic [ADDRW-1:0] req_addr = '0;
  logic [31:0]      req_wdata = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDRW(ADDRW), .INIT_ZERO(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // One request at minimum spacing: handshake at edge k, rsp_valid low at the
  // negedge after k, high at the negedge after k+1, taken at edge k+2.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [ADDRW-1:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                     input string name);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s idle_ready got=%b want=1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL %s access_valid got=%b want=0", name, rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d || rsp_err !== exp_e) begin
      n_bad++;
      $display("FAIL %s resp got v=%b d=%h e=%b want v=1 d=%h e=%b",
               name, rsp_valid, rsp_rdata, rsp_err, exp_d, exp_e);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_release got ready=%b v=%b want 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_word();
    txn(1'b1, F3_W, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, "sw_010");
    txn(1'b0, F3_W, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, "lw_010");
  endtask

  task automatic test_lanes();
    txn(1'b1, F3_B,  12'h011, 32'hAAAAAA7F, 32'h0, 1'b0, "sb_011");
    txn(1'b0, F3_B,  12'h011, 32'h0, 32'h0000007F, 1'b0, "lb_011");
    txn(1'b0, F3_W,  12'h010, 32'h0, 32'hDEAD7FEF, 1'b0, "lw_010_after_sb");
    txn(1'b0, F3_BU, 12'h013, 32'h0, 32'h000000DE, 1'b0, "lbu_013");
    txn(1'b0, F3_H,  12'h012, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_012");
    txn(1'b0, F3_HU, 12'h010, 32'h0, 32'h00007FEF, 1'b0, "lhu_010");
    txn(1'b0, F3_B,  12'h010, 32'h0, 32'hFFFFFFEF, 1'b0, "lb_010");
    txn(1'b1, F3_H,  12'h022, 32'h0000BEEF, 32'h0, 1'b0, "sh_022");
    txn(1'b0, F3_HU, 12'h022, 32'h0, 32'h0000BEEF, 1'b0, "lhu_022");
  endtask

  task automatic test_errors();
    txn(1'b0, F3_W,   12'h012, 32'h0, 32'h0, 1'b1, "lw_misaligned");
    txn(1'b1, F3_H,   12'h013, 32'h0000FFFF, 32'h0, 1'b1, "sh_misaligned");
    txn(1'b1, 3'b100, 12'h010, 32'h11111111, 32'h0, 1'b1, "store_f3_100");
    txn(1'b0, 3'b011, 12'h010, 32'h0, 32'h0, 1'b1, "load_f3_011");
    txn(1'b0, F3_W,   12'h010, 32'h0, 32'hDEAD7FEF, 1'b0, "lw_after_errors");
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 12'h010;
    rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD7FEF || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_%0d got v=%b d=%h ready=%b want v=1 d=DEAD7FEF ready=0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      // A store offered while busy must be dropped.
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_wdata = 32'hFFFFFFFF;
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    txn(1'b0, F3_W, 12'h010, 32'h0, 32'hDEAD7FEF, 1'b0, "lw_after_hold");
  endtask

  task automatic test_reset_abort();
    txn(1'b1, F3_W, 12'h020, 32'hCAFEF00D, 32'h0, 1'b0, "sw_020_prior");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 12'h020;
    req_wdata = 32'h12345678;
    @(posedge clk); #1 req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL abort_outputs got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL abort_release got ready=%b v=%b want 1/0", req_ready, rsp_valid);
    end
    txn(1'b0, F3_W, 12'h020, 32'h0, 32'hCAFEF00D, 1'b0, "lw_020_after_abort");
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 12'h010;
    rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL resp_reset got v=%b d=%h want 0/0", rsp_valid, rsp_rdata);
    end
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
    txn(1'b0, F3_B, 12'h013, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_013_after_reset");
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end

endmodule
